// File: rtl/cmul_rr_scheduler.sv
// Round-robin front end that shares one complex multiplier among N_REQ requesters.
// One operation is in flight at a time: grant, issue, wait for the result, deliver it.
module cmul_rr_scheduler #(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 16,
  parameter int RES_WIDTH  = 66,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sw_rst,
  input  logic [N_REQ-1:0]              req_val,
  input  logic [N_REQ*4*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          mul_op_val,
  input  logic                          mul_op_ready,
  output logic [4*DATA_WIDTH-1:0]       mul_op_data,
  input  logic                          mul_res_val,
  output logic                          mul_res_ready,
  input  logic [RES_WIDTH-1:0]          mul_res_data,
  output logic [N_REQ-1:0]              rsp_val,
  input  logic [N_REQ-1:0]              rsp_ready,
  output logic [RES_WIDTH-1:0]          rsp_data,
  output logic [$clog2(N_REQ)-1:0]      owner_id,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int OP_W = 4 * DATA_WIDTH;
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DELIVER = 2'd3;

  logic [1:0]           state;
  logic [ID_W-1:0]      rr_ptr;
  logic [15:0]          wd_cnt;
  logic [OP_W-1:0]      op_reg;
  logic [RES_WIDTH-1:0] res_reg;
  logic                 quiet;
  logic                 grant_found;
  logic [ID_W-1:0]      grant_idx;
  logic [ID_W-1:0]      owner_next;

  // Any reset in progress suppresses every handshake, so nothing is accepted or offered.
  assign quiet         = rst | sw_rst;
  assign busy          = (state != S_IDLE);
  assign mul_op_val    = (state == S_ISSUE) && !quiet;
  assign mul_res_ready = (state == S_WAIT) && !quiet;
  assign mul_op_data   = op_reg;
  assign rsp_data      = res_reg;
  assign owner_next    = (owner_id == ID_W'(N_REQ - 1)) ? '0 : owner_id + ID_W'(1);

  // Search starts at rr_ptr and wraps, so the last served requester goes to the back.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_found && req_val[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_val   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = !quiet && (state == S_IDLE) && grant_found && (grant_idx == ID_W'(i));
      rsp_val[i]   = !quiet && (state == S_DELIVER) && (owner_id == ID_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      owner_id    <= '0;
      wd_cnt      <= '0;
      op_reg      <= '0;
      res_reg     <= '0;
      timeout_err <= 1'b0;
    end else if (sw_rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      owner_id    <= '0;
      wd_cnt      <= '0;
      op_reg      <= '0;
      res_reg     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            op_reg   <= req_data[int'(grant_idx)*OP_W +: OP_W];
            owner_id <= grant_idx;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mul_op_ready) begin
            wd_cnt <= '0;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A result on the final watchdog cycle still wins over the abort.
          if (mul_res_val) begin
            res_reg <= mul_res_data;
            state   <= S_DELIVER;
          end else if (wd_cnt == WD_LAST) begin
            timeout_err <= 1'b1;
            rr_ptr      <= owner_next;
            state       <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        S_DELIVER: begin
          if (rsp_ready[owner_id]) begin
            rr_ptr <= owner_next;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
